sram_ctrl: RTL and testbench

Synchronous initiator for one external asynchronous 32-bit SRAM bank. It turns single-word CPU-side read/write requests into properly sequenced `ram_ce_n`/`ram_oe_n`/`ram_we_n`/`ram_be_n` pin activity with a tri-stated `ram_data` bus. It sits between the memory arbiter and the board SRAM pins, and is the counterpart of the SRAM device model used in the top-level bench.

---
 rtl/sram_ctrl_pkg.sv | 25 ++
 rtl/sram_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared peripheral types for the SRAM initiator.
// Word, address, mask types, the tri-state idle word and the FSM enum.
package sram_ctrl_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [19:0] Ram_addr_t;
  typedef logic [3:0]  Mask_t;
  typedef logic        Bit_t;

  localparam Word_t HIGH_WORD = {32{1'bz}};

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } Sram_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word initiator for an asynchronous 32-bit SRAM.
// Optional SRAM_CTRL_STAT_EN adds read/write completion counters.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  Ram_addr_t   addr,
  input  Word_t       wdata,
  input  Mask_t       be,
  output Word_t       rdata,
  output logic        ack,
  output logic        busy,
  inout  wire  [31:0] ram_data,
  output Ram_addr_t   ram_addr,
  output Mask_t       ram_be_n,
  output Bit_t        ram_ce_n,
  output Bit_t        ram_oe_n,
  output Bit_t        ram_we_n
`ifdef SRAM_CTRL_STAT_EN
  ,
  output Word_t       rd_count,
  output Word_t       wr_count
`endif
);

  localparam int CW =
    $clog2(max2(READ_WAIT, WRITE_WAIT) + 1);
  localparam logic [CW-1:0] RD_INIT = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_INIT = CW'(WRITE_WAIT - 1);

  Sram_state_t   state;
  logic [CW-1:0] cnt;
  Word_t         wdata_q;
  logic          drive;

  assign ram_data = drive ? wdata_q : HIGH_WORD;

  // Sequencer: pins are set for the state being entered, so all are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wdata_q  <= '0;
      drive    <= 1'b0;
      rdata    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      ram_addr <= '0;
      ram_be_n <= '1;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            wdata_q  <= wdata;
            ram_addr <= addr;
            ram_ce_n <= 1'b0;
            busy     <= 1'b1;
            if (we) begin
              state    <= WR_SETUP;
              ram_be_n <= ~be;
              drive    <= 1'b1;
            end else begin
              state    <= RD;
              cnt      <= RD_INIT;
              ram_be_n <= '0;
              ram_oe_n <= 1'b0;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            rdata    <= ram_data;
            state    <= DONE;
            ack      <= 1'b1;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_be_n <= '1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_SETUP: begin
          state    <= WR_PULSE;
          cnt      <= WR_INIT;
          ram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            state    <= WR_HOLD;
            ram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HOLD: begin
          state    <= DONE;
          ack      <= 1'b1;
          drive    <= 1'b0;
          ram_ce_n <= 1'b1;
          ram_be_n <= '1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_CTRL_STAT_EN
  logic we_q;

  // Remember the direction of the accepted request for the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
    end else if (state == IDLE && req) begin
      we_q <= we;
    end
  end

  // Completion counters, bumped on each ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (ack) begin
      if (we_q) wr_count <= wr_count + 1'b1;
      else      rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with behavioural SRAMs.
// Two instances: default waits and READ_WAIT=3 / WRITE_WAIT=2.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      req0, req1, we;
  Ram_addr_t addr;
  Word_t     wdata;
  Mask_t     be;

  Word_t     rdata0, rdata1;
  logic      ack0, ack1, busy0, busy1;
  wire [31:0] ram_data0, ram_data1;
  Ram_addr_t ram_addr0, ram_addr1;
  Mask_t     ram_be_n0, ram_be_n1;
  Bit_t      ce_n0, oe_n0, we_n0;
  Bit_t      ce_n1, oe_n1, we_n1;
`ifdef SRAM_CTRL_STAT_EN
  Word_t     rd_count0, wr_count0, rd_count1, wr_count1;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  sram_ctrl u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we),
    .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata0), .ack(ack0), .busy(busy0),
    .ram_data(ram_data0), .ram_addr(ram_addr0),
    .ram_be_n(ram_be_n0), .ram_ce_n(ce_n0),
    .ram_oe_n(oe_n0), .ram_we_n(we_n0)
`ifdef SRAM_CTRL_STAT_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  sram_ctrl #(.READ_WAIT(3), .WRITE_WAIT(2)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we),
    .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata1), .ack(ack1), .busy(busy1),
    .ram_data(ram_data1), .ram_addr(ram_addr1),
    .ram_be_n(ram_be_n1), .ram_ce_n(ce_n1),
    .ram_oe_n(oe_n1), .ram_we_n(we_n1)
`ifdef SRAM_CTRL_STAT_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup (ram_data0[i]);
    pullup (ram_data1[i]);
  end

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  assign ram_data0 = (!ce_n0 && !oe_n0) ?
    mem0[ram_addr0[7:0]] : 32'hzzzz_zzzz;
  assign ram_data1 = (!ce_n1 && !oe_n1) ?
    mem1[ram_addr1[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!ce_n0 && !we_n0)
      for (int i = 0; i < 4; i++)
        if (!ram_be_n0[i])
          mem0[ram_addr0[7:0]][8*i +: 8] <= ram_data0[8*i +: 8];
  end

  always @(posedge clk) begin
    if (!ce_n1 && !we_n1)
      for (int j = 0; j < 4; j++)
        if (!ram_be_n1[j])
          mem1[ram_addr1[7:0]][8*j +: 8] <= ram_data1[8*j +: 8];
  end

  always @(negedge clk) begin
    if (!oe_n0 && !we_n0) viol++;
    if (!oe_n1 && !we_n1) viol++;
    if (!ce_n0 && !oe_n0 && ram_data0 !== mem0[ram_addr0[7:0]]) viol++;
    if (!ce_n1 && !oe_n1 && ram_data1 !== mem1[ram_addr1[7:0]]) viol++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int    lat, oe_lo, we_lo, acks;
  Word_t rd;

  // One transfer from an IDLE negedge; returns at the next IDLE negedge.
  task automatic xfer(input bit sel, input bit w,
                      input Ram_addr_t a, input Word_t d,
                      input Mask_t b);
    bit got;
    we = w; addr = a; wdata = d; be = b;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    lat = 0; oe_lo = 0; we_lo = 0; rd = '0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      if ((sel ? oe_n1 : oe_n0) == 1'b0) oe_lo++;
      if ((sel ? we_n1 : we_n0) == 1'b0) we_lo++;
      if (sel ? ack1 : ack0) begin
        got = 1'b1;
        rd  = sel ? rdata1 : rdata0;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); @(negedge clk);
    check("ack_pulse", sel ? ack1 : ack0, 1'b0);
    check("busy_idle", sel ? busy1 : busy0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem0[k] = '0; mem1[k] = '0;
    end
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ack",   ack0,      1'b0);
    check("rst_busy",  busy0,     1'b0);
    check("rst_rdata", rdata0,    32'h0);
    check("rst_ce_n",  ce_n0,     1'b1);
    check("rst_oe_n",  oe_n0,     1'b1);
    check("rst_we_n",  we_n0,     1'b1);
    check("rst_be_n",  ram_be_n0, 4'hF);
    check("rst_addr",  ram_addr0, 20'h0);
    check("rst_data_z", ram_data0, 32'hFFFF_FFFF);

    xfer(0, 1, 20'h00010, 32'hDEADBEEF, 4'hF);
    check("wr_lat", lat, 4);
    check("wr_we_lo", we_lo, 1);
    xfer(0, 0, 20'h00010, 32'h0, 4'h0);
    check("rd_lat", lat, 2);
    check("rd_oe_lo", oe_lo, 1);
    check("rd_data", rd, 32'hDEADBEEF);

    xfer(0, 1, 20'h00030, 32'h11223344, 4'hF);
    xfer(0, 1, 20'h00030, 32'hAABBCCDD, 4'b0101);
    check("rdata_hold", rdata0, 32'hDEADBEEF);
    xfer(0, 0, 20'h00030, 32'h0, 4'h0);
    check("lane_data", rd, 32'h11BB33DD);

    xfer(0, 1, 20'h00010, 32'h0, 4'h0);
    check("be0_lat", lat, 4);
    xfer(0, 0, 20'h00010, 32'h0, 4'h0);
    check("be0_data", rd, 32'hDEADBEEF);

    xfer(1, 1, 20'h00050, 32'h12345678, 4'hF);
    check("w2_lat", lat, 5);
    check("w2_we_lo", we_lo, 2);
    check("w2_oe_lo", oe_lo, 0);
    xfer(1, 0, 20'h00050, 32'h0, 4'h0);
    check("r3_lat", lat, 4);
    check("r3_oe_lo", oe_lo, 3);
    check("r3_data", rd, 32'h12345678);

    addr = 20'h00020; wdata = 32'h5555AAAA; be = 4'hF;
    we = 1'b0; req0 = 1'b1; acks = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); @(negedge clk);
      if (ack0) begin acks++; we = ~we; end
    end
    req0 = 1'b0;
    check("cont_acks", acks, 4);
    @(posedge clk); @(negedge clk);
    check("cont_idle", busy0, 1'b0);

    we = 1'b0; req0 = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    check("rstreq_busy", busy0, 1'b0);
    check("rstreq_ce_n", ce_n0, 1'b1);
    @(posedge clk); @(negedge clk);
    check("rstreq_drop", busy0, 1'b0);

    we = 1'b1; addr = 20'h00040; wdata = 32'hCAFEF00D;
    be = 4'hF; req0 = 1'b1;
    @(posedge clk); @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pulse_we_n", we_n0, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_we_n", we_n0, 1'b1);
    check("abort_ce_n", ce_n0, 1'b1);
    check("abort_busy", busy0, 1'b0);
    check("abort_ack",  ack0,  1'b0);
    check("abort_z",    ram_data0, 32'hFFFF_FFFF);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("abort_noack", ack0, 1'b0);
    end

`ifdef SRAM_CTRL_STAT_EN
    check("stat_rd0", rd_count0, 32'd0);
    check("stat_wr0", wr_count0, 32'd0);
    xfer(0, 0, 20'h00001, 32'h0, 4'h0);
    xfer(0, 1, 20'h00002, 32'h1, 4'hF);
    xfer(0, 0, 20'h00003, 32'h0, 4'h0);
    xfer(0, 1, 20'h00004, 32'h2, 4'hF);
    xfer(0, 0, 20'h00005, 32'h0, 4'h0);
    check("stat_rd3", rd_count0, 32'd3);
    check("stat_wr2", wr_count0, 32'd2);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("stat_rd_clr", rd_count0, 32'd0);
    check("stat_wr_clr", wr_count0, 32'd0);
`endif

    check("protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
